// File: rtl/dac_update_scheduler_pkg.sv
// rtl/dac_update_scheduler_pkg.sv - shared constants and FSM state type for the DAC update scheduler
//
// Purpose: code width, channel selectors, the driver's minimum frame length
// and the scheduler FSM state encoding, shared by the top and its arbiter.
package dac_update_scheduler_pkg;

    localparam int DAC_CODE_W       = 12;
    localparam logic CHAN_A         = 1'b0;
    localparam logic CHAN_B         = 1'b1;
    // 42 serial bit-times of 16 clocks each for one A+B frame.
    localparam int DRIVER_MIN_FRAME = 42 * 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        FRAME  = 2'd2,
        GAP    = 2'd3
    } state_t;

endpackage

// File: rtl/dac_update_scheduler_rr_arbiter2.sv
// rtl/dac_update_scheduler_rr_arbiter2.sv - two-input round-robin grant
//
// Purpose: grants at most one of two requesters per cycle. A lone requester
// always wins; on a tie the requester that did not win the previous tie is
// granted. Grants are combinational and held low during reset.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_valid0, i_valid1     request lines
//   o_grant0, o_grant1     one-hot (or zero) grant, same cycle as request
module rr_arbiter2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_valid0,
    input  logic i_valid1,
    output logic o_grant0,
    output logic o_grant1
);
    import dac_update_scheduler_pkg::*;

    // 1 means requester 1 won the last tie, so requester 0 wins the next one.
    logic r_rr_last;
    logic w_tie;

    assign w_tie    = i_valid0 & i_valid1;
    assign o_grant0 = ~i_rst & i_valid0 & (~i_valid1 | r_rr_last);
    assign o_grant1 = ~i_rst & i_valid1 & (~i_valid0 | ~r_rr_last);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_last <= 1'b1;
        end else if (w_tie) begin
            r_rr_last <= o_grant1;
        end
    end

endmodule

// File: rtl/dac_update_scheduler.sv
// rtl/dac_update_scheduler.sv - shares the dual-channel serial DAC driver between two writers
//
// Purpose: keeps A/B shadow codes, coalesces writes into the fewest frames,
// and launches the driver with a one-cycle en pulse, timing each frame
// itself because the driver has no busy output.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req0_valid/chan/data, req0_ready host write port (chan 0 = A, 1 = B)
//   req1_valid/chan/data, req1_ready ramp-engine write port
//   force_update                     re-send shadows even when not dirty
//   dac_en                           launch pulse to the driver
//   dac_a_data, dac_b_data           frame codes, held for the whole frame
//   busy                             high from launch to end of gap
//   frames_done                      wrapping completed-frame counter
module dac_update_scheduler
    import dac_update_scheduler_pkg::*;
#(
    parameter int FRAME_CYCLES = 700,
    parameter int GAP_CYCLES   = 4,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic                  req0_chan,
    input  logic [DAC_CODE_W-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic                  req1_chan,
    input  logic [DAC_CODE_W-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  force_update,
    output logic                  dac_en,
    output logic [DAC_CODE_W-1:0] dac_a_data,
    output logic [DAC_CODE_W-1:0] dac_b_data,
    output logic                  busy,
    output logic [CNT_W-1:0]      frames_done
);

    localparam int TIMER_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] FRAME_LOAD = TIMER_W'(FRAME_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? TIMER_W'(GAP_CYCLES - 1) : '0;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [TIMER_W-1:0]    r_timer;
    logic [DAC_CODE_W-1:0] r_shadow_a;
    logic [DAC_CODE_W-1:0] r_shadow_b;
    logic                  r_dirty;
    logic                  r_force_pend;
    logic                  w_snapshot;
    logic                  w_frame_end;
    logic                  w_wr_en;
    logic                  w_wr_chan;
    logic [DAC_CODE_W-1:0] w_wr_data;

    rr_arbiter2 u_arb (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .o_grant0 (req0_ready),
        .o_grant1 (req1_ready)
    );

    assign w_wr_en   = req0_ready | req1_ready;
    assign w_wr_chan = req0_ready ? req0_chan : req1_chan;
    assign w_wr_data = req0_ready ? req0_data : req1_data;

    assign dac_en = (r_state == LAUNCH);
    assign busy   = (r_state != IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_snapshot  = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_dirty | r_force_pend) begin
                    w_snapshot  = 1'b1;
                    w_state_nxt = LAUNCH;
                end
            end
            LAUNCH: w_state_nxt = FRAME;
            FRAME: begin
                if (r_timer == '0) begin
                    w_frame_end = 1'b1;
                    if (GAP_CYCLES > 0) w_state_nxt = GAP;
                    else                w_state_nxt = IDLE;
                end
            end
            GAP: begin
                if (r_timer == '0) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer      <= '0;
            r_shadow_a   <= '0;
            r_shadow_b   <= '0;
            r_dirty      <= 1'b0;
            r_force_pend <= 1'b0;
            dac_a_data   <= '0;
            dac_b_data   <= '0;
            frames_done  <= '0;
        end else begin
            if (w_wr_en) begin
                if (w_wr_chan == CHAN_B) r_shadow_b <= w_wr_data;
                else                     r_shadow_a <= w_wr_data;
            end
            // A set in the snapshot cycle wins, so a write racing the
            // snapshot still gets its own frame.
            if (w_wr_en)         r_dirty <= 1'b1;
            else if (w_snapshot) r_dirty <= 1'b0;
            if (force_update)    r_force_pend <= 1'b1;
            else if (w_snapshot) r_force_pend <= 1'b0;

            if (w_snapshot) begin
                dac_a_data <= r_shadow_a;
                dac_b_data <= r_shadow_b;
            end

            case (r_state)
                LAUNCH: r_timer <= FRAME_LOAD;
                FRAME: begin
                    if (r_timer == '0) r_timer <= GAP_LOAD;
                    else               r_timer <= r_timer - TIMER_W'(1);
                end
                GAP: begin
                    if (r_timer != '0) r_timer <= r_timer - TIMER_W'(1);
                end
                default: r_timer <= r_timer;
            endcase

            if (w_frame_end) frames_done <= frames_done + CNT_W'(1);
        end
    end

    // A shorter frame would relaunch the driver before it has finished.
    always_ff @(posedge clk) begin
        assert (FRAME_CYCLES >= DRIVER_MIN_FRAME)
            else $error("FRAME_CYCLES %0d below driver minimum %0d", FRAME_CYCLES, DRIVER_MIN_FRAME);
    end

endmodule

// File: tb/tb_dac_update_scheduler.sv
// tb/tb_dac_update_scheduler.sv - self-checking bench for dac_update_scheduler
module tb_dac_update_scheduler;
    import dac_update_scheduler_pkg::*;

    localparam int FRAME = 700;
    localparam int GAP   = 4;
    localparam int CW    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic            req0_valid = 1'b0, req0_chan = 1'b0;
    logic            req1_valid = 1'b0, req1_chan = 1'b0;
    logic [11:0]     req0_data = '0, req1_data = '0;
    logic            force_update = 1'b0;
    logic            req0_ready, req1_ready, dac_en, busy;
    logic [11:0]     dac_a_data, dac_b_data;
    logic [CW-1:0]   frames_done;

    dac_update_scheduler #(.FRAME_CYCLES(FRAME), .GAP_CYCLES(GAP), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_chan    (req0_chan),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_chan    (req1_chan),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .force_update (force_update),
        .dac_en       (dac_en),
        .dac_a_data   (dac_a_data),
        .dac_b_data   (dac_b_data),
        .busy         (busy),
        .frames_done  (frames_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: shadows and a pending flag, plus the launch cycle and
    // the first cycle at which a new snapshot is allowed.
    bit            m_known = 1'b0;
    bit            m_rr;
    logic [11:0]   m_sh [2];
    bit            m_pend;
    logic [11:0]   m_a, m_b;
    logic [CW-1:0] m_frames;
    int            m_launch;
    int            m_free;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_rr     = 1'b1;
        m_sh[0]  = '0;
        m_sh[1]  = '0;
        m_pend   = 1'b0;
        m_a      = '0;
        m_b      = '0;
        m_frames = '0;
        m_launch = -1000000;
        m_free   = 0;
        m_known  = 1'b1;
    endtask

    task automatic step(input bit r, input bit v0, input bit c0, input logic [11:0] d0,
                        input bit v1, input bit c1, input logic [11:0] d1, input bit f);
        bit g0, g1, snap;
        rst = r; req0_valid = v0; req0_chan = c0; req0_data = d0;
        req1_valid = v1; req1_chan = c1; req1_data = d1; force_update = f;
        g0 = 1'b0; g1 = 1'b0;
        if (!r) begin
            if (v0 && v1) begin
                if (m_rr) g0 = 1'b1; else g1 = 1'b1;
            end else begin
                g0 = v0; g1 = v1;
            end
        end
        #1;
        if (m_known) begin
            chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
            chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
            chk("dac_en", {31'd0, dac_en}, {31'd0, cyc == m_launch});
            chk("busy", {31'd0, busy}, {31'd0, (cyc >= m_launch) && (cyc < m_free)});
            chk("dac_a_data", {20'd0, dac_a_data}, {20'd0, m_a});
            chk("dac_b_data", {20'd0, dac_b_data}, {20'd0, m_b});
            chk("frames_done", {16'd0, frames_done}, {16'd0, m_frames});
        end
        if (r) begin
            model_reset();
        end else begin
            if (cyc == m_launch + FRAME) m_frames = m_frames + 1'b1;
            snap = (cyc >= m_free) && m_pend;
            if (snap) begin
                m_a      = m_sh[0];
                m_b      = m_sh[1];
                m_launch = cyc + 1;
                m_free   = cyc + FRAME + GAP + 2;
                m_pend   = 1'b0;
            end
            if (g0) begin m_sh[c0] = d0; m_pend = 1'b1; end
            if (g1) begin m_sh[c1] = d1; m_pend = 1'b1; end
            if (v0 && v1) m_rr = g1;
            if (f) m_pend = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 12'h0, 0, 0, 12'h0, 0);
    endtask

    task automatic wait_launch(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            idle(1);
            if (dac_en) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 2000 && busy; i++) idle(1);
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1;
        // Reset, then a long quiet stretch with no launches.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 12'h0, 0, 0, 12'h0, 0);
        idle(2000);
        chk("quiet_frames", {16'd0, frames_done}, 32'd0);

        // Single host write: launch two cycles later with A only.
        step(0, 1, CHAN_A, 12'h4D8, 0, 0, 12'h0, 0);
        idle(1);
        chk("first_launch_en", {31'd0, dac_en}, 32'd1);
        chk("first_launch_a", {20'd0, dac_a_data}, 32'h4D8);
        chk("first_launch_b", {20'd0, dac_b_data}, 32'h0);

        // Coalescing: three writes during the frame give one more frame.
        idle(10);
        step(0, 0, 0, 12'h0, 1, CHAN_B, 12'h4D9, 0);
        idle(5);
        step(0, 0, 0, 12'h0, 1, CHAN_B, 12'h123, 0);
        idle(5);
        step(0, 0, 0, 12'h0, 1, CHAN_A, 12'hFFF, 0);
        wait_launch("coalesce_launch");
        chk("coalesce_a", {20'd0, dac_a_data}, 32'hFFF);
        chk("coalesce_b", {20'd0, dac_b_data}, 32'h123);
        idle(1500);
        chk("coalesce_frames", {16'd0, frames_done}, 32'd2);

        // Both requesters valid for four cycles straight out of reset.
        for (int i = 0; i < 2; i++) step(1, 0, 0, 12'h0, 0, 0, 12'h0, 0);
        for (int k = 0; k < 4; k++)
            step(0, 1, CHAN_A, 12'(32'h100 + k), 1, CHAN_B, 12'(32'h200 + k), 0);
        wait_launch("rr_launch");
        chk("rr_a", {20'd0, dac_a_data}, 32'h102);
        chk("rr_b", {20'd0, dac_b_data}, 32'h203);

        // Write landing on the snapshot cycle goes out in the following frame.
        wait_idle("snap_idle");
        step(0, 1, CHAN_A, 12'h0AA, 0, 0, 12'h0, 0);
        step(0, 1, CHAN_A, 12'h0BB, 0, 0, 12'h0, 0);
        chk("snap_en", {31'd0, dac_en}, 32'd1);
        chk("snap_old_a", {20'd0, dac_a_data}, 32'h0AA);
        wait_launch("snap_next_launch");
        chk("snap_new_a", {20'd0, dac_a_data}, 32'h0BB);

        // Reset 300 cycles into a frame, then recover and force a re-send.
        wait_idle("rst_idle");
        step(0, 1, CHAN_B, 12'h5A5, 0, 0, 12'h0, 0);
        idle(302);
        step(1, 0, 0, 12'h0, 0, 0, 12'h0, 0);
        chk("rst_en", {31'd0, dac_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_a", {20'd0, dac_a_data}, 32'h0);
        chk("rst_b", {20'd0, dac_b_data}, 32'h0);
        chk("rst_frames", {16'd0, frames_done}, 32'd0);
        step(0, 1, CHAN_A, 12'h321, 0, 0, 12'h0, 0);
        idle(1);
        chk("post_rst_en", {31'd0, dac_en}, 32'd1);
        chk("post_rst_a", {20'd0, dac_a_data}, 32'h321);
        wait_idle("force_idle");
        idle(5);
        step(0, 0, 0, 12'h0, 0, 0, 12'h0, 1);
        wait_launch("force_launch");
        chk("force_a", {20'd0, dac_a_data}, 32'h321);
        chk("force_b", {20'd0, dac_b_data}, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 15000; i++) begin
            step($urandom_range(0, 5999) == 0,
                 $urandom_range(0, 15) == 0, 1'($urandom), 12'($urandom),
                 $urandom_range(0, 11) == 0, 1'($urandom), 12'($urandom),
                 $urandom_range(0, 399) == 0);
        end
        idle(800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
